// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// a safe clog2 helper and the read-port index type.
package regfile_pkg;

    localparam int REGFILE_WIDTH    = 32;
    localparam int REGFILE_DEPTH    = 32;
    localparam int REGFILE_NUM_READ = 2;

    // Read ports are limited to four, so a two-bit index covers them all.
    typedef logic [1:0] rd_port_idx_t;

    // Address width that never collapses to zero, even for a depth of 1.
    function automatic int clog2_safe(input int value);
        int result;
        result = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register-file write, read and issue signals.
// master = ID/WB pipeline side, slave = the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter int NUM_READ = REGFILE_NUM_READ
);
    localparam int AW = clog2_safe(DEPTH);

    logic                      regwrite;
    logic [AW-1:0]             writereg;
    logic [WIDTH-1:0]          writeda;
    logic [NUM_READ*AW-1:0]    readreg;
    logic [NUM_READ*WIDTH-1:0] readda;
    logic [NUM_READ-1:0]       rd_busy;
    logic                      issue_en;
    logic [AW-1:0]             issue_reg;
    logic                      any_busy;

    modport master (
        output regwrite, writereg, writeda, readreg, issue_en, issue_reg,
        input  readda, rd_busy, any_busy
    );

    modport slave (
        input  regwrite, writereg, writeda, readreg, issue_en, issue_reg,
        output readda, rd_busy, any_busy
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending-producer vector. An issue sets a bit, a write-back
// clears it; when both hit the same register the set wins because the new
// producer supersedes the retiring one. Register 0 is never pending when
// ZERO_REG is 1.
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_en,
    input  logic [$clog2(DEPTH)-1:0] clr_reg,
    input  logic                     set_en,
    input  logic [$clog2(DEPTH)-1:0] set_reg,
    output logic [DEPTH-1:0]         pending
);

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;

    // Clear first, then set, so a simultaneous set on the same register wins.
    always_comb begin
        pending_next = pending_reg;
        if (clr_en) begin
            pending_next[clr_reg] = 1'b0;
        end
        if (set_en) begin
            pending_next[set_reg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_next[0] = 1'b0;
        end
    end

    // Pending state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the ID stage: WIDTH x DEPTH
// flop array, NUM_READ combinational read ports, optional hard-wired zero
// register and a pending scoreboard used by the hazard unit.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward the write-back
// data (and mask the busy flag) to a read port addressing the same register
// in the same cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int DEPTH    = REGFILE_DEPTH,
    parameter int NUM_READ = REGFILE_NUM_READ,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             write_ok;

    // Writes to the hard-wired zero register are dropped.
    assign write_ok = bus.regwrite && !((ZERO_REG != 0) && (bus.writereg == '0));

    // Data array: cleared asynchronously, written on the WB edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_ok) begin
            mem_reg[bus.writereg] <= bus.writeda;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .clr_en  (bus.regwrite),
        .clr_reg (bus.writereg),
        .set_en  (bus.issue_en),
        .set_reg (bus.issue_reg),
        .pending (pending)
    );

    assign bus.any_busy = |pending;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [AW-1:0]    addr;
            logic             is_zero;
            logic             bypass_hit;
            logic [WIDTH-1:0] rd_data;
            logic             rd_pend;

            assign addr    = bus.readreg[gi*AW +: AW];
            assign is_zero = (ZERO_REG != 0) && (addr == '0);
`ifdef REGFILE_MP_BYPASS_EN
            // Forwarding is suppressed during reset so outputs stay at zero.
            assign bypass_hit = bus.regwrite && !rst && (bus.writereg == addr);
`else
            assign bypass_hit = 1'b0;
`endif

            // Read mux: zero register first, then bypass, then stored state.
            always_comb begin
                rd_data = mem_reg[addr];
                rd_pend = pending[addr];
                if (is_zero) begin
                    rd_data = '0;
                    rd_pend = 1'b0;
                end else if (bypass_hit) begin
                    rd_data = bus.writeda;
                    rd_pend = pending[addr] & bus.issue_en & (bus.issue_reg == addr);
                end
            end

            assign bus.readda[gi*WIDTH +: WIDTH] = rd_data;
            assign bus.rd_busy[gi]               = rd_pend;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 32x32 three-port instance for the
// main scenarios and a 16x8 four-port instance for the parameter sweep.
module tb_regfile_mp;

    logic clk;
    logic rst;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_READ(3)) bus_a ();
    regfile_mp_if #(.WIDTH(16), .DEPTH(8),  .NUM_READ(4)) bus_b ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(3), .ZERO_REG(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(8), .NUM_READ(4), .ZERO_REG(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] exp_v;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.regwrite  = 1'b0;
        bus_a.writereg  = '0;
        bus_a.writeda   = '0;
        bus_a.issue_en  = 1'b0;
        bus_a.issue_reg = '0;
    endtask

    task automatic test_reset();
        // Write and issue presented while reset is held must be discarded.
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd6; bus_a.writeda = 32'h5;
        bus_a.issue_en = 1'b1; bus_a.issue_reg = 5'd6;
        bus_a.readreg  = {5'd6, 5'd6, 5'd6};
        exp_q.push_back(128'h0);
        exp_q.push_back(128'h0);
        step();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL reset_hold_data got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.any_busy !== exp_v[0]) begin
            errors++; $display("FAIL reset_hold_busy got %b want %b", bus_a.any_busy, exp_v[0]);
        end
        // Release reset mid-cycle, then write r6=5 and issue r2 on the same edge.
        rst = 1'b0;
        bus_a.issue_reg = 5'd2;
        exp_q.push_back({32'h0, 32'h5, 32'h5, 32'h5});
        exp_q.push_back(128'h1);
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL reset_prewrite got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.any_busy !== exp_v[0]) begin
            errors++; $display("FAIL reset_preissue got %b want %b", bus_a.any_busy, exp_v[0]);
        end
        // Asynchronous reset pulse in the middle of the cycle clears at once.
        #2 rst = 1'b1;
        exp_q.push_back(128'h0);
        exp_q.push_back(128'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL reset_async_data got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.any_busy, bus_a.rd_busy} !== exp_v[3:0]) begin
            errors++; $display("FAIL reset_async_busy got %b want %b", {bus_a.any_busy, bus_a.rd_busy}, exp_v[3:0]);
        end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd6; bus_a.writeda = 32'h5;
        step();
        bus_a.writereg = 5'd3; bus_a.writeda = 32'hA5A5_0001;
        step();
        idle_a();
        bus_a.readreg = {5'd6, 5'd3, 5'd1};
        exp_q.push_back({32'h0, 32'h5, 32'hA5A5_0001, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL basic_read got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        // Duplicate addresses on every port.
        bus_a.readreg = {5'd3, 5'd3, 5'd3};
        exp_q.push_back({32'h0, {3{32'hA5A5_0001}}});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL basic_dup got %h want %h", bus_a.readda, exp_v[95:0]);
        end
    endtask

    task automatic test_zero();
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd0; bus_a.writeda = 32'hFFFF_FFFF;
        bus_a.issue_en = 1'b1; bus_a.issue_reg = 5'd0;
        bus_a.readreg  = {5'd0, 5'd0, 5'd0};
        exp_q.push_back(128'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL zero_pre got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        exp_q.push_back(128'h0);
        exp_q.push_back(128'h0);
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda !== exp_v[95:0]) begin
            errors++; $display("FAIL zero_data got %h want %h", bus_a.readda, exp_v[95:0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.any_busy, bus_a.rd_busy} !== exp_v[3:0]) begin
            errors++; $display("FAIL zero_busy got %b want %b", {bus_a.any_busy, bus_a.rd_busy}, exp_v[3:0]);
        end
    endtask

    task automatic test_bypass();
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd7; bus_a.writeda = 32'h1234;
        bus_a.readreg  = {5'd0, 5'd0, 5'd7};
        exp_q.push_back(BYPASS ? 128'h1234 : 128'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda[31:0] !== exp_v[31:0]) begin
            errors++; $display("FAIL bypass_pre got %h want %h", bus_a.readda[31:0], exp_v[31:0]);
        end
        exp_q.push_back(128'h1234);
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.readda[31:0] !== exp_v[31:0]) begin
            errors++; $display("FAIL bypass_post got %h want %h", bus_a.readda[31:0], exp_v[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        bus_a.readreg = {5'd0, 5'd10, 5'd9};
        // Issue r9: busy only after the edge.
        bus_a.issue_en = 1'b1; bus_a.issue_reg = 5'd9;
        exp_q.push_back(128'h0);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.rd_busy[0] !== exp_v[0]) begin
            errors++; $display("FAIL sb_issue_pre got %b want %b", bus_a.rd_busy[0], exp_v[0]);
        end
        exp_q.push_back(128'h3);
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.any_busy, bus_a.rd_busy[0]} !== exp_v[1:0]) begin
            errors++; $display("FAIL sb_issue got %b want %b", {bus_a.any_busy, bus_a.rd_busy[0]}, exp_v[1:0]);
        end
        // Write r9: same-cycle view depends on bypass, then busy clears.
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd9; bus_a.writeda = 32'h77;
        exp_q.push_back(BYPASS ? {1'b0, 32'h77} : {1'b1, 32'h0});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.rd_busy[0], bus_a.readda[31:0]} !== exp_v[32:0]) begin
            errors++; $display("FAIL sb_write_pre got %h want %h", {bus_a.rd_busy[0], bus_a.readda[31:0]}, exp_v[32:0]);
        end
        exp_q.push_back({2'b00, 32'h77});
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.any_busy, bus_a.rd_busy[0], bus_a.readda[31:0]} !== exp_v[33:0]) begin
            errors++; $display("FAIL sb_write got %h want %h", {bus_a.any_busy, bus_a.rd_busy[0], bus_a.readda[31:0]}, exp_v[33:0]);
        end
        // Re-issue r9, then write r9 while issuing r10 on the same edge.
        bus_a.issue_en = 1'b1; bus_a.issue_reg = 5'd9;
        step();
        bus_a.issue_reg = 5'd10;
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd9; bus_a.writeda = 32'h55;
        exp_q.push_back({2'b10, 32'h55});
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.rd_busy[1:0], bus_a.readda[31:0]} !== exp_v[33:0]) begin
            errors++; $display("FAIL sb_diff_regs got %h want %h", {bus_a.rd_busy[1:0], bus_a.readda[31:0]}, exp_v[33:0]);
        end
        // Issue and write r9 on the same edge: set wins, data still updates.
        bus_a.issue_en = 1'b1; bus_a.issue_reg = 5'd9;
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd9; bus_a.writeda = 32'h88;
        exp_q.push_back(BYPASS ? {1'b0, 32'h88} : {1'b0, 32'h55});
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.rd_busy[0], bus_a.readda[31:0]} !== exp_v[32:0]) begin
            errors++; $display("FAIL sb_same_pre got %h want %h", {bus_a.rd_busy[0], bus_a.readda[31:0]}, exp_v[32:0]);
        end
        exp_q.push_back({1'b1, 32'h88});
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if ({bus_a.rd_busy[0], bus_a.readda[31:0]} !== exp_v[32:0]) begin
            errors++; $display("FAIL sb_same got %h want %h", {bus_a.rd_busy[0], bus_a.readda[31:0]}, exp_v[32:0]);
        end
        // Retire both producers; nothing should remain pending.
        bus_a.regwrite = 1'b1; bus_a.writereg = 5'd9; bus_a.writeda = 32'h99;
        step();
        bus_a.writereg = 5'd10; bus_a.writeda = 32'hAA;
        exp_q.push_back(128'h0);
        step();
        idle_a();
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus_a.any_busy !== exp_v[0]) begin
            errors++; $display("FAIL sb_drain got %b want %b", bus_a.any_busy, exp_v[0]);
        end
    endtask

    task automatic test_sweep();
        bus_b.regwrite = 1'b1; bus_b.writereg = 3'd7; bus_b.writeda = 16'hBEEF;
        bus_b.readreg  = {3'd7, 3'd7, 3'd7, 3'd7};
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(128'hBEEF);
        end
        step();
        bus_b.regwrite = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_v = exp_q.pop_front(); checks++;
            if (bus_b.readda[p*16 +: 16] !== exp_v[15:0]) begin
                errors++; $display("FAIL sweep_port%0d got %h want %h", p, bus_b.readda[p*16 +: 16], exp_v[15:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_a();
        bus_a.readreg   = '0;
        bus_b.regwrite  = 1'b0;
        bus_b.writereg  = '0;
        bus_b.writeda   = '0;
        bus_b.readreg   = '0;
        bus_b.issue_en  = 1'b0;
        bus_b.issue_reg = '0;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_scoreboard();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
